// File: rtl/vram_write_scheduler.sv
// Arbitrates the single VRAM write port between per-cell character writes and
// bulk fill commands that expand into one beat per cell over a row/column span.
module vram_write_scheduler #(
    parameter int unsigned ROWS  = 32,
    parameter int unsigned COLS  = 80,
    parameter int unsigned ROW_W = 5,
    parameter int unsigned COL_W = 7
) (
    input  logic               clk,
    input  logic               reset,
    output logic               char_ready,
    input  logic               char_valid,
    input  logic [ROW_W-1:0]   char_row,
    input  logic [COL_W-1:0]   char_col,
    input  logic [7:0]         char_byte,
    output logic               fill_ready,
    input  logic               fill_valid,
    input  logic [ROW_W-1:0]   fill_row,
    input  logic [ROW_W:0]     fill_rows,
    input  logic [COL_W-1:0]   fill_col_first,
    input  logic [COL_W-1:0]   fill_col_last,
    input  logic [7:0]         fill_byte,
    output logic               busy,
    input  logic               vram_ready,
    output logic               vram_valid,
    output logic [ROW_W-1:0]   vram_row,
    output logic [COL_W-1:0]   vram_col,
    output logic [7:0]         vram_byte
);

    localparam int unsigned RCNT_W = ROW_W + 1;
    localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(COLS - 1);
    localparam logic [RCNT_W-1:0] ROWS_CNT = RCNT_W'(ROWS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CHAR = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [7:0]          byte_q, byte_d;
    logic [COL_W-1:0]    col_first_q, col_first_d;
    logic [COL_W-1:0]    col_last_q, col_last_d;
    logic [RCNT_W-1:0]   rows_left_q, rows_left_d;
    logic                vram_valid_q, vram_valid_d;
    logic                busy_q, busy_d;

    logic [COL_W-1:0]    col_last_c;
    logic [RCNT_W-1:0]   rows_c;
    logic                fill_nop_c;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            byte_q       <= '0;
            col_first_q  <= '0;
            col_last_q   <= '0;
            rows_left_q  <= '0;
            vram_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            byte_q       <= byte_d;
            col_first_q  <= col_first_d;
            col_last_q   <= col_last_d;
            rows_left_q  <= rows_left_d;
            vram_valid_q <= vram_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state, acceptance and fill-walk logic
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        byte_d      = byte_q;
        col_first_d = col_first_q;
        col_last_d  = col_last_q;
        rows_left_d = rows_left_q;
        char_ready  = 1'b0;
        fill_ready  = 1'b0;

        col_last_c = (fill_col_last > COL_MAX) ? COL_MAX : fill_col_last;
        rows_c     = (fill_rows > ROWS_CNT) ? ROWS_CNT : fill_rows;
        fill_nop_c = (rows_c == '0) || (fill_col_first > col_last_c);

        case (state_q)
            IDLE: begin
                char_ready = 1'b1;
                fill_ready = ~char_valid;
                if (char_valid) begin
                    row_d   = char_row;
                    col_d   = char_col;
                    byte_d  = char_byte;
                    state_d = CHAR;
                end else if (fill_valid && !fill_nop_c) begin
                    row_d       = fill_row;
                    col_d       = fill_col_first;
                    byte_d      = fill_byte;
                    col_first_d = fill_col_first;
                    col_last_d  = col_last_c;
                    rows_left_d = rows_c;
                    state_d     = FILL;
                end
            end
            CHAR: begin
                char_ready = vram_ready;
                if (vram_ready) begin
                    if (char_valid) begin
                        row_d  = char_row;
                        col_d  = char_col;
                        byte_d = char_byte;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FILL: begin
                if (vram_ready) begin
                    if (col_q != col_last_q) begin
                        col_d = col_q + COL_W'(1);
                    end else if (rows_left_q > RCNT_W'(1)) begin
                        // Row wraps to follow the circular screen buffer
                        col_d       = col_first_q;
                        row_d       = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
                        rows_left_d = rows_left_q - RCNT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            char_ready = 1'b0;
            fill_ready = 1'b0;
        end

        vram_valid_d = (state_d != IDLE);
        busy_d       = (state_d != IDLE);
    end

    assign vram_valid = vram_valid_q;
    assign busy       = busy_q;
    assign vram_row   = row_q;
    assign vram_col   = col_q;
    assign vram_byte  = byte_q;

endmodule
